mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Two-requester round-robin arbiter that shares one off-chip memory port between two master channels. Each channel uses the existing oe/we/addr/Wdata/size + DataRdy handshake. The arbiter sits between the accelerator's master channels and the simulated or external memory model, so two accelerator instances can share one memory. It serialises transactions, forwards the memory response to the granted requester, and flags protocol errors and stalled memory via a watchdog.

Parameters:
ADDR_W, 9, address width per channel
DATA_W, 8, data width per channel
SIZE_W, 4, data_ram_size width per channel
TIMEOUT, 255, max cycles in BUSY without m_rdy before error (must be >=1)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
r0_oe  in  1  requester 0 read enable
r0_we  in  1  requester 0 write enable
r0_addr  in  ADDR_W  requester 0 address
r0_wdata  in  DATA_W  requester 0 write data
r0_size  in  SIZE_W  requester 0 access size in bits
r0_rdata  out  DATA_W  read data to requester 0
r0_rdy  out  1  transaction-complete strobe to requester 0
r1_oe, r1_we, r1_addr, r1_wdata, r1_size, r1_rdata, r1_rdy  same as r0_*, for requester 1
m_oe  out  1  memory read enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_size  out  SIZE_W  memory access size
m_rdata  in  DATA_W  memory read data
m_rdy  in  1  memory DataRdy
busy  out  1  high while in BUSY
grant  out  1  index of the current or last granted requester
err  out  1  sticky error flag

Behaviour:
- Request: req_i = ri_oe | ri_we. A requester holds all its signals stable until it sees ri_rdy, then drops them the next cycle.
- Reset (async, any state): state=IDLE, timeout counter=0, err=0, busy=0, grant=1 (so r0 wins first). All m_*, ri_rdy and ri_rdata are 0 immediately. An in-flight transaction is abandoned.
- State IDLE:
  - All m_* = 0, ri_rdy = 0, m_rdy is ignored.
  - On a rising edge with any req_i: go to BUSY and latch grant.
  - If both requesters request, the one not equal to grant wins (round-robin); otherwise the single requester wins.
- State BUSY:
  - m_* are driven combinationally from the granted requester's live inputs. The non-granted requester is held off (ri_rdy=0, ri_rdata=0).
  - m_rdy=1: forward in the same cycle. r[grant]_rdy=1 and r[grant]_rdata=m_rdata (for writes, rdata=m_rdata, don't-care). Next state is IDLE.
  - Granted requester drops both oe and we before m_rdy: abort to IDLE on the next edge, no rdy, no error.
  - Granted requester drives oe & we together: go to ERR on the next edge.
  - Counter: cleared on BUSY entry, increments each BUSY cycle without m_rdy. On reaching TIMEOUT, go to ERR.
- Timing:
  - Minimum turnaround is one IDLE cycle between consecutive grants. With memory latency L cycles, each transaction occupies L BUSY cycles plus 1 IDLE cycle.
  - Request first sampled at edge N: m_oe/m_we are high from just after edge N.
- State ERR:
  - err=1 (sticky). m_*=0, ri_rdy=0, busy=0.
  - All requests are ignored. Only reset exits ERR.
- Width rules: no arithmetic on the data path. The counter width is clog2(TIMEOUT+1) and it saturates at TIMEOUT.
- Simultaneous events:
  - m_rdy and a drop of the request in the same cycle: the rdy is delivered (completion wins).
  - m_rdy and the timeout reached in the same cycle: completion wins.

Test Plan:
1. Single read: after reset, r0 reads addr 0x05; memory answers with latency 2, m_rdata=0xA5. Required: m_oe=1, m_addr=0x05 for 2 cycles; r0_rdy=1 and r0_rdata=0xA5 in the m_rdy cycle; r1_rdy=0 throughout; busy drops next cycle.
2. Contention: r0 read addr 0x10 and r1 write addr 0x20 data 0x3C, both asserted in the same cycle after reset. Required: r0 is served first (grant=0); after one IDLE cycle r1 is served with m_we=1, m_addr=0x20, m_wdata=0x3C. A repeated simultaneous pair is then served r0 then r1 again (alternation).
3. Starvation check: r1 requests continuously while r0 requests once mid-stream. Required: r0 is granted at the next IDLE after the current r1 transaction; r1 does not get two consecutive grants while r0 is pending.
4. Timeout: TIMEOUT=8, r1 reads and m_rdy is held at 0. Required: err=1 after 8 BUSY cycles; m_oe=0; a new r0 request is ignored until reset.
5. Protocol error: the granted r0 drives oe=1 and we=1 together. Required: err=1 on the next edge; no rdy is issued to either requester.
6. Reset mid-transaction: assert reset during BUSY, 1 cycle before m_rdy. Required: m_*, r0_rdy, r1_rdy and busy go to 0 immediately without waiting for an edge. After release, with both requesting, r0 wins.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one memory port (oe/we/addr/wdata/size + rdy).
// Serialises transactions, forwards the response to the granted requester, flags protocol errors and memory stalls.
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_oe,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [SIZE_W-1:0] r0_size,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_rdy,
  input  logic              r1_oe,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [SIZE_W-1:0] r1_size,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_rdy,
  output logic              m_oe,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [SIZE_W-1:0] m_size,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rdy,
  output logic              busy,
  output logic              grant,
  output logic              err
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               req0, req1;
  logic               g_oe, g_we;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [SIZE_W-1:0]  g_size;

  assign req0 = r0_oe | r0_we;
  assign req1 = r1_oe | r1_we;

  // Live view of whichever requester currently holds the grant.
  always_comb begin
    if (grant_q) begin
      g_oe    = r1_oe;
      g_we    = r1_we;
      g_addr  = r1_addr;
      g_wdata = r1_wdata;
      g_size  = r1_size;
    end else begin
      g_oe    = r0_oe;
      g_we    = r0_we;
      g_addr  = r0_addr;
      g_wdata = r0_wdata;
      g_size  = r0_size;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    m_oe     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_size   = '0;
    r0_rdy   = 1'b0;
    r1_rdy   = 1'b0;
    r0_rdata = '0;
    r1_rdata = '0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req0 || req1) begin
          state_d = S_BUSY;
          // On contention the requester not served last time wins.
          grant_d = (req0 && req1) ? ~grant_q : req1;
        end
      end

      S_BUSY: begin
        m_oe    = g_oe;
        m_we    = g_we;
        m_addr  = g_addr;
        m_wdata = g_wdata;
        m_size  = g_size;
        if (!m_rdy && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

        if (g_oe && g_we) begin
          state_d = S_ERR;
        end else if (m_rdy) begin
          // Completion takes priority over a dropped request or an expiring watchdog.
          state_d = S_IDLE;
          if (grant_q) begin
            r1_rdy   = 1'b1;
            r1_rdata = m_rdata;
          end else begin
            r0_rdy   = 1'b1;
            r0_rdata = m_rdata;
          end
        end else if (!g_oe && !g_we) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_END) begin
          state_d = S_ERR;
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q == S_BUSY);
  assign err   = (state_q == S_ERR);
  assign grant = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: single read, contention, fairness,
// watchdog timeout, protocol error and asynchronous reset in mid-transaction.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int SIZE_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              r0_oe, r0_we, r1_oe, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic [SIZE_W-1:0] r0_size, r1_size;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              r0_rdy, r1_rdy;
  logic              m_oe, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [SIZE_W-1:0] m_size;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rdy;
  logic              busy, grant, err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W),
    .TIMEOUT(8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .r0_oe   (r0_oe),
    .r0_we   (r0_we),
    .r0_addr (r0_addr),
    .r0_wdata(r0_wdata),
    .r0_size (r0_size),
    .r0_rdata(r0_rdata),
    .r0_rdy  (r0_rdy),
    .r1_oe   (r1_oe),
    .r1_we   (r1_we),
    .r1_addr (r1_addr),
    .r1_wdata(r1_wdata),
    .r1_size (r1_size),
    .r1_rdata(r1_rdata),
    .r1_rdy  (r1_rdy),
    .m_oe    (m_oe),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_size  (m_size),
    .m_rdata (m_rdata),
    .m_rdy   (m_rdy),
    .busy    (busy),
    .grant   (grant),
    .err     (err)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where stimulus changes.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    r0_oe = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0; r0_size = '0;
    r1_oe = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0; r1_size = '0;
    m_rdy = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    clear_inputs();
    #1 reset = 1'b1;
    #1;
    check("rst_busy",  busy,  1'b0);
    check("rst_err",   err,   1'b0);
    check("rst_grant", grant, 1'b1);
    check("rst_m_oe",  m_oe,  1'b0);
    check("rst_r0rdy", r0_rdy, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cyc();

    // 1. Single read, latency 2
    r0_oe = 1; r0_addr = 9'h005; r0_size = 4'd8;
    @(negedge clock);
    check("t1_idle_m_oe", m_oe, 1'b0);
    cyc();
    @(negedge clock);
    check("t1_b1_m_oe",   m_oe,   1'b1);
    check("t1_b1_m_addr", m_addr, 9'h005);
    check("t1_b1_m_size", m_size, 4'd8);
    check("t1_b1_busy",   busy,   1'b1);
    check("t1_b1_grant",  grant,  1'b0);
    check("t1_b1_r0rdy",  r0_rdy, 1'b0);
    check("t1_b1_r1rdy",  r1_rdy, 1'b0);
    cyc();
    m_rdy = 1; m_rdata = 8'hA5;
    @(negedge clock);
    check("t1_b2_m_oe",    m_oe,     1'b1);
    check("t1_b2_m_addr",  m_addr,   9'h005);
    check("t1_b2_r0rdy",   r0_rdy,   1'b1);
    check("t1_b2_r0rdata", r0_rdata, 8'hA5);
    check("t1_b2_r1rdy",   r1_rdy,   1'b0);
    cyc();
    r0_oe = 0; m_rdy = 0;
    @(negedge clock);
    check("t1_done_busy",  busy,   1'b0);
    check("t1_done_r0rdy", r0_rdy, 1'b0);
    check("t1_done_m_oe",  m_oe,   1'b0);

    // 2. Contention and alternation
    do_reset();
    r0_oe = 1; r0_addr = 9'h010;
    r1_we = 1; r1_addr = 9'h020; r1_wdata = 8'h3C;
    cyc();
    m_rdy = 1; m_rdata = 8'h77;
    @(negedge clock);
    check("t2_a_grant",   grant,    1'b0);
    check("t2_a_m_oe",    m_oe,     1'b1);
    check("t2_a_m_we",    m_we,     1'b0);
    check("t2_a_m_addr",  m_addr,   9'h010);
    check("t2_a_r0rdy",   r0_rdy,   1'b1);
    check("t2_a_r0rdata", r0_rdata, 8'h77);
    check("t2_a_r1rdy",   r1_rdy,   1'b0);
    check("t2_a_r1rdata", r1_rdata, 8'h00);
    cyc();
    r0_oe = 0; m_rdy = 0;
    @(negedge clock);
    check("t2_gap_busy", busy, 1'b0);
    check("t2_gap_m_we", m_we, 1'b0);
    cyc();
    m_rdy = 1;
    @(negedge clock);
    check("t2_b_grant",   grant,   1'b1);
    check("t2_b_m_we",    m_we,    1'b1);
    check("t2_b_m_oe",    m_oe,    1'b0);
    check("t2_b_m_addr",  m_addr,  9'h020);
    check("t2_b_m_wdata", m_wdata, 8'h3C);
    check("t2_b_r1rdy",   r1_rdy,  1'b1);
    check("t2_b_r0rdy",   r0_rdy,  1'b0);
    cyc();
    r1_we = 0; m_rdy = 0;
    cyc();
    r0_oe = 1; r1_we = 1;
    cyc();
    m_rdy = 1;
    @(negedge clock);
    check("t2_c_grant",  grant,  1'b0);
    check("t2_c_r0rdy",  r0_rdy, 1'b1);
    cyc();
    r0_oe = 0; m_rdy = 0;
    cyc();
    m_rdy = 1;
    @(negedge clock);
    check("t2_d_grant",  grant,  1'b1);
    check("t2_d_r1rdy",  r1_rdy, 1'b1);
    cyc();
    r1_we = 0; m_rdy = 0;
    cyc();

    // 3. Fairness: r1 requests continuously, r0 joins mid-transaction
    r1_oe = 1; r1_addr = 9'h030;
    cyc();
    m_rdy = 1;
    @(negedge clock);
    check("t3_a_grant", grant,  1'b1);
    check("t3_a_r1rdy", r1_rdy, 1'b1);
    cyc();
    m_rdy = 0;
    @(negedge clock);
    check("t3_gap1_busy", busy, 1'b0);
    cyc();
    r0_oe = 1; r0_addr = 9'h040;
    @(negedge clock);
    check("t3_b_grant",  grant,  1'b1);
    check("t3_b_m_addr", m_addr, 9'h030);
    check("t3_b_r0rdy",  r0_rdy, 1'b0);
    cyc();
    m_rdy = 1;
    @(negedge clock);
    check("t3_b_r1rdy", r1_rdy, 1'b1);
    cyc();
    m_rdy = 0;
    @(negedge clock);
    check("t3_gap2_busy", busy, 1'b0);
    cyc();
    m_rdy = 1;
    @(negedge clock);
    check("t3_c_grant",  grant,  1'b0);
    check("t3_c_m_addr", m_addr, 9'h040);
    check("t3_c_r0rdy",  r0_rdy, 1'b1);
    check("t3_c_r1rdy",  r1_rdy, 1'b0);
    cyc();
    r0_oe = 0; m_rdy = 0;
    cyc();
    m_rdy = 1;
    @(negedge clock);
    check("t3_d_grant", grant,  1'b1);
    check("t3_d_r1rdy", r1_rdy, 1'b1);
    cyc();
    r1_oe = 0; m_rdy = 0;

    // 4. Watchdog timeout after 8 BUSY cycles without m_rdy
    do_reset();
    r1_oe = 1; r1_addr = 9'h055;
    cyc();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      check($sformatf("t4_busy_c%0d", i), busy, 1'b1);
      check($sformatf("t4_err_c%0d", i),  err,  1'b0);
      cyc();
    end
    @(negedge clock);
    check("t4_err",   err,  1'b1);
    check("t4_busy",  busy, 1'b0);
    check("t4_m_oe",  m_oe, 1'b0);
    cyc();
    r0_oe = 1; r0_addr = 9'h011;
    repeat (3) cyc();
    @(negedge clock);
    check("t4_hold_err",   err,    1'b1);
    check("t4_hold_busy",  busy,   1'b0);
    check("t4_hold_m_oe",  m_oe,   1'b0);
    check("t4_hold_r0rdy", r0_rdy, 1'b0);
    check("t4_hold_r1rdy", r1_rdy, 1'b0);

    // 5. Protocol error: granted r0 drives oe and we together
    do_reset();
    r0_oe = 1; r0_we = 1; r0_addr = 9'h066;
    cyc();
    @(negedge clock);
    check("t5_busy",    busy,   1'b1);
    check("t5_b_err",   err,    1'b0);
    check("t5_b_r0rdy", r0_rdy, 1'b0);
    cyc();
    @(negedge clock);
    check("t5_err",     err,    1'b1);
    check("t5_r0rdy",   r0_rdy, 1'b0);
    check("t5_r1rdy",   r1_rdy, 1'b0);
    check("t5_m_we",    m_we,   1'b0);

    // 6. Asynchronous reset one cycle before m_rdy
    do_reset();
    r0_oe = 1; r0_addr = 9'h077;
    cyc();
    cyc();
    @(negedge clock);
    check("t6_pre_m_oe", m_oe, 1'b1);
    check("t6_pre_busy", busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_m_oe",   m_oe,   1'b0);
    check("t6_rst_m_addr", m_addr, 9'h000);
    check("t6_rst_busy",   busy,   1'b0);
    check("t6_rst_r0rdy",  r0_rdy, 1'b0);
    check("t6_rst_r1rdy",  r1_rdy, 1'b0);
    r1_oe = 1; r1_addr = 9'h088;
    @(negedge clock);
    check("t6_held_busy", busy, 1'b0);
    reset = 1'b0;
    cyc();
    @(negedge clock);
    check("t6_grant",  grant,  1'b0);
    check("t6_busy",   busy,   1'b1);
    check("t6_m_addr", m_addr, 9'h077);
    check("t6_r1rdy",  r1_rdy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
